// File: rtl/x_tile_row_sequencer.sv
// Walks one X tile row by row: start_k/k_idx per row, waits row_valid, acks with row_accept, ends with tile_valid.
// Optional macro X_TILE_SEQ_PERF_EN enables the perf_cycles busy-cycle counter; all outputs are registered.
module x_tile_row_sequencer #(
    parameter int KMAX    = 1024,
    parameter int K_W     = 10,
    parameter int TIMEOUT = 200,
    parameter int TMR_W   = 8
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           tile_start,
    input  logic [K_W-1:0] k_base,
    input  logic [K_W:0]   k_len,
    input  logic           abort,
    output logic           busy,
    output logic           start_k,
    output logic [K_W-1:0] k_idx,
    input  logic           row_valid,
    output logic           row_accept,
    output logic           tile_valid,
    input  logic           tile_ready,
    output logic [K_W:0]   rows_done,
    output logic           err,
    output logic [1:0]     err_code,
    output logic [31:0]    perf_cycles
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT_ROW,
        S_ACCEPT,
        S_DONE
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_RANGE   = 2'd1;
    localparam logic [1:0] ERR_TIMEOUT = 2'd2;

    state_t           state_q, state_d;
    logic [K_W:0]     k_len_q, k_len_d;
    logic [K_W:0]     rows_done_q, rows_done_d;
    logic [K_W:0]     rows_inc;
    logic [K_W-1:0]   k_idx_q, k_idx_d;
    logic             err_q, err_d;
    logic [1:0]       err_code_q, err_code_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic             busy_q, start_k_q, row_accept_q, tile_valid_q;
    logic [K_W+1:0]   end_row;

    // Two extra bits so base+len can never wrap below KMAX.
    assign end_row  = {2'b00, k_base} + {1'b0, k_len};
    assign rows_inc = rows_done_q + (K_W+1)'(1);

    always_comb begin
        state_d     = state_q;
        k_len_d     = k_len_q;
        rows_done_d = rows_done_q;
        k_idx_d     = k_idx_q;
        err_d       = err_q;
        err_code_d  = err_code_q;
        timer_d     = timer_q;
        if (abort) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (tile_start) begin
                        k_len_d     = k_len;
                        rows_done_d = '0;
                        err_d       = 1'b0;
                        err_code_d  = ERR_NONE;
                        if (k_len == '0) begin
                            state_d = S_DONE;
                        end else if (end_row > (K_W+2)'(KMAX)) begin
                            state_d    = S_DONE;
                            err_d      = 1'b1;
                            err_code_d = ERR_RANGE;
                        end else begin
                            state_d = S_ISSUE;
                            k_idx_d = k_base;
                        end
                    end
                end
                S_ISSUE: begin
                    timer_d = '0;
                    state_d = S_WAIT_ROW;
                end
                S_WAIT_ROW: begin
                    // row_valid wins over a timeout expiring in the same cycle.
                    if (row_valid) begin
                        state_d = S_ACCEPT;
                    end else if (timer_q == TMR_W'(TIMEOUT - 1)) begin
                        state_d    = S_DONE;
                        err_d      = 1'b1;
                        err_code_d = ERR_TIMEOUT;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                S_ACCEPT: begin
                    rows_done_d = rows_inc;
                    if (rows_inc == k_len_q) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_ISSUE;
                        k_idx_d = k_idx_q + K_W'(1);
                    end
                end
                S_DONE: begin
                    if (tile_ready) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            k_len_q      <= '0;
            rows_done_q  <= '0;
            k_idx_q      <= '0;
            err_q        <= 1'b0;
            err_code_q   <= ERR_NONE;
            timer_q      <= '0;
            busy_q       <= 1'b0;
            start_k_q    <= 1'b0;
            row_accept_q <= 1'b0;
            tile_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            k_len_q      <= k_len_d;
            rows_done_q  <= rows_done_d;
            k_idx_q      <= k_idx_d;
            err_q        <= err_d;
            err_code_q   <= err_code_d;
            timer_q      <= timer_d;
            busy_q       <= (state_d != S_IDLE);
            start_k_q    <= (state_d == S_ISSUE);
            row_accept_q <= (state_d == S_ACCEPT);
            tile_valid_q <= (state_d == S_DONE);
        end
    end

    assign busy       = busy_q;
    assign start_k    = start_k_q;
    assign k_idx      = k_idx_q;
    assign row_accept = row_accept_q;
    assign tile_valid = tile_valid_q;
    assign rows_done  = rows_done_q;
    assign err        = err_q;
    assign err_code   = err_code_q;

`ifdef X_TILE_SEQ_PERF_EN
    logic [31:0] perf_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_q <= '0;
        end else if (state_q == S_IDLE && tile_start && !abort) begin
            perf_q <= '0;
        end else if ((state_q == S_ISSUE || state_q == S_WAIT_ROW || state_q == S_ACCEPT)
                     && perf_q != 32'hFFFF_FFFF) begin
            perf_q <= perf_q + 32'd1;
        end
    end

    assign perf_cycles = perf_q;
`else
    assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_x_tile_row_sequencer.sv
// Directed/randomized bench for x_tile_row_sequencer with a latency-programmable fetcher model.
module tb_x_tile_row_sequencer;

    localparam int KMAX    = 1024;
    localparam int K_W     = 10;
    localparam int TIMEOUT = 200;

    logic           clk = 1'b0;
    logic           rst_n;
    logic           tile_start;
    logic [K_W-1:0] k_base;
    logic [K_W:0]   k_len;
    logic           abort;
    logic           busy, start_k, row_accept, tile_valid, err;
    logic [K_W-1:0] k_idx;
    logic           row_valid;
    logic           tile_ready;
    logic [K_W:0]   rows_done;
    logic [1:0]     err_code;
    logic [31:0]    perf_cycles;

    int n_checks = 0;
    int n_errors = 0;

    // Fetcher model controls (written by main sequence) and observations.
    int lat_lo, lat_hi;
    bit hang;
    int lat_sum;
    int acc_cnt;
    int obs_q[$];

    x_tile_row_sequencer #(.KMAX(KMAX), .K_W(K_W), .TIMEOUT(TIMEOUT), .TMR_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .tile_start(tile_start), .k_base(k_base), .k_len(k_len),
        .abort(abort), .busy(busy), .start_k(start_k), .k_idx(k_idx), .row_valid(row_valid),
        .row_accept(row_accept), .tile_valid(tile_valid), .tile_ready(tile_ready),
        .rows_done(rows_done), .err(err), .err_code(err_code), .perf_cycles(perf_cycles)
    );

    always #5 clk = ~clk;

    // Fetcher: raises row_valid d negedges after seeing start_k, drops it on row_accept.
    initial begin
        int cnt;
        int d;
        cnt = 0;
        lat_sum = 0;
        row_valid = 1'b0;
        forever begin
            @(negedge clk);
            if (!busy) begin
                row_valid = 1'b0;
                cnt = 0;
            end else begin
                if (row_accept) row_valid = 1'b0;
                if (start_k) begin
                    if (!hang) begin
                        d = $urandom_range(lat_hi, lat_lo);
                        cnt = d;
                        lat_sum = lat_sum + d + 2;
                    end
                end else if (cnt > 0) begin
                    cnt = cnt - 1;
                    if (cnt == 0) row_valid = 1'b1;
                end
            end
        end
    end

    initial begin
        acc_cnt = 0;
        forever begin
            @(negedge clk);
            if (start_k) obs_q.push_back(int'(k_idx));
            if (row_accept) acc_cnt = acc_cnt + 1;
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL global_timeout: observed no finish, required finish");
        $fatal(1, "global timeout");
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, {4'd0, busy, start_k, row_accept, tile_valid, err, err_code, k_idx, rows_done, perf_cycles}, 64'd0);
    endtask

    task automatic handshake(input int hold, input int exp_rows);
        for (int i = 0; i < hold; i++) begin
            chk("tv_hold", tile_valid, 1);
            @(negedge clk);
        end
        chk("tv_before_hs", tile_valid, 1);
        tile_ready = 1'b1;
        @(negedge clk);
        tile_ready = 1'b0;
        chk("tv_drop", tile_valid, 0);
        chk("busy_idle", busy, 0);
        chk("rows_hold", rows_done, exp_rows);
    endtask

    task automatic run_tile(input int base, input int len, input int lo, input int hi, input int hold);
        int s0, a0, l0, nst, cyc, budget, exp_rows;
        logic exp_err;
        logic [31:0] exp_perf;
        s0 = obs_q.size();
        a0 = acc_cnt;
        l0 = lat_sum;
        lat_lo = lo;
        lat_hi = hi;
        exp_err  = (len != 0) && (base + len > KMAX);
        exp_rows = (len == 0 || exp_err) ? 0 : len;
        @(negedge clk);
        tile_start = 1'b1;
        k_base = K_W'(base);
        k_len  = (K_W+1)'(len);
        @(negedge clk);
        tile_start = 1'b0;
        @(negedge clk);
        // A stray command mid-tile must be ignored.
        tile_start = 1'b1;
        k_base = K_W'($urandom);
        k_len  = (K_W+1)'($urandom);
        @(negedge clk);
        tile_start = 1'b0;
        budget = len * (hi + 4) + 50;
        cyc = 0;
        while (!tile_valid && cyc < budget) begin
            @(negedge clk);
            cyc++;
        end
        chk("tile_valid_seen", tile_valid, 1);
        chk("rows_done", rows_done, exp_rows);
        chk("err", err, exp_err);
        chk("err_code", err_code, exp_err ? 1 : 0);
        nst = obs_q.size() - s0;
        chk("start_count", nst, exp_rows);
        chk("accept_count", acc_cnt - a0, exp_rows);
        for (int i = 0; i < nst && i < exp_rows; i++)
            chk("k_idx_seq", obs_q[s0 + i], base + i);
`ifdef X_TILE_SEQ_PERF_EN
        exp_perf = 32'(lat_sum - l0);
`else
        exp_perf = 32'd0;
`endif
        chk("perf_cycles", perf_cycles, exp_perf);
        handshake(hold, exp_rows);
    endtask

    initial begin
        int s0, n;
        logic [31:0] exp_perf;
        rst_n = 1'b0;
        tile_start = 1'b0;
        k_base = '0;
        k_len = '0;
        abort = 1'b0;
        tile_ready = 1'b0;
        hang = 1'b0;
        lat_lo = 1;
        lat_hi = 1;

        repeat (2) @(negedge clk);
        chk_zero("reset_outputs");
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("idle_after_reset");

        // Basic tile and single-row tile with held tile_ready.
        run_tile(0, 8, 10, 10, 0);
        run_tile(9, 1, 10, 10, 5);

        // Range boundaries and empty tile.
        run_tile(1020, 5, 1, 3, 2);
        run_tile(1019, 5, 1, 3, 0);
        run_tile(0, 0, 1, 3, 1);
        run_tile(1, 1024, 1, 1, 0);
        run_tile(1023, 1, 1, 4, 0);
        run_tile(0, 1024, 1, 1, 0);

        // Watchdog: fetcher silent.
        hang = 1'b1;
        @(negedge clk);
        tile_start = 1'b1;
        k_base = 10'd77;
        k_len = 11'd3;
        @(negedge clk);
        tile_start = 1'b0;
        chk("to_start_k", start_k, 1);
        n = 0;
        while (!tile_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        chk("to_latency", n, TIMEOUT + 1);
        chk("to_err", err, 1);
        chk("to_err_code", err_code, 2);
        chk("to_rows", rows_done, 0);
`ifdef X_TILE_SEQ_PERF_EN
        exp_perf = 32'(TIMEOUT + 1);
`else
        exp_perf = 32'd0;
`endif
        chk("to_perf", perf_cycles, exp_perf);
        handshake(1, 0);
        hang = 1'b0;

        // row_valid arriving in the timer's last cycle still wins.
        run_tile(5, 1, TIMEOUT, TIMEOUT, 0);

        for (int t = 0; t < 8; t++)
            run_tile($urandom_range(1023, 0), $urandom_range(6, 0), 1, 12, $urandom_range(3, 0));

        // Abort during the third row's wait.
        lat_lo = 10;
        lat_hi = 10;
        s0 = obs_q.size();
        @(negedge clk);
        tile_start = 1'b1;
        k_base = 10'd50;
        k_len = 11'd5;
        @(negedge clk);
        tile_start = 1'b0;
        n = 0;
        while (obs_q.size() - s0 < 3 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("ab_third_issue", obs_q.size() - s0, 3);
        repeat (3) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("ab_busy", busy, 0);
        chk("ab_tile_valid", tile_valid, 0);
        chk("ab_start_k", start_k, 0);
        chk("ab_rows", rows_done, 2);
        chk("ab_err", err, 0);
        n = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (tile_valid || busy) n++;
        end
        chk("ab_stays_idle", n, 0);
        chk("ab_no_more_starts", obs_q.size() - s0, 3);

        // Asynchronous reset mid-row.
        lat_lo = 10;
        lat_hi = 10;
        @(negedge clk);
        tile_start = 1'b1;
        k_base = 10'd200;
        k_len = 11'd3;
        @(negedge clk);
        tile_start = 1'b0;
        repeat (16) @(negedge clk);
        chk("rst_pre_busy", busy, 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk_zero("rst_async_zero");
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk_zero("rst_idle");
        run_tile(3, 2, 1, 5, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
